bcd_count_ctrl: RTL and testbench
=================================

# bcd_count_ctrl

Sequencing controller for the 3-digit BCD count datapath (units/tens/hundreds). It owns the digit registers and drives them from a small command interface: start, stop, clear, BCD preset load, count direction and a terminal-count target. A prescaler paces the count. It sits between panel/testbench command logic and the BCD display path, and replaces free-running ripple operation with controlled run/pause/terminate behaviour.

## Interface
- `TICK_DIV`, default 10: clock cycles per count step; legal range 1..1023.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: level-sampled command; begin or resume counting.
- `stop` input 1: pause counting; hold the digits and the prescaler.
- `clear` input 1: force the count to 000 and the state to IDLE.
- `load` input 1: preset the count from `load_val`.
- `load_val` input 12: BCD preset. [11:8] is hundreds, [7:4] is tens, [3:0] is units.
- `dir` input 1: 0 counts up, 1 counts down. Sampled on every step.
- `target` input 12: BCD terminal value, same packing as `load_val`.
- `units`, `tens`, `hundreds` output 4 each: registered BCD digits.
- `busy` output 1: high while the state is RUN.
- `done` output 1: one-cycle pulse on the step that reaches `target`.
- `wrap` output 1: one-cycle pulse when a step crosses 999→000 (up) or 000→999 (down).
- `load_err` output 1: one-cycle pulse when a load is rejected.

## Operation
- States are IDLE, RUN, PAUSE and DONE.
- Reset value: IDLE, digits 000, prescaler 0, all pulse outputs 0, `busy` 0.
- Command priority within one cycle is clear > load > stop > start. Only the highest-priority asserted command acts.
- clear, from any state: digits go to 000, prescaler to 0, state to IDLE.
- load:
  - Accepted in IDLE, PAUSE and DONE. The digits take `load_val`, the prescaler goes to 0, the state goes to IDLE.
  - In RUN, load is ignored with no error.
  - If any nibble of `load_val` is greater than 9, the load is rejected: digits unchanged, `load_err` pulses.
- stop: RUN→PAUSE. Ignored in other states. The prescaler value is held.
- start:
  - IDLE→RUN and DONE→RUN: the prescaler restarts at 0.
  - PAUSE→RUN: the prescaler continues from its held value.
  - Ignored in RUN.
- Prescaler: in RUN it increments each cycle. At `TICK_DIV-1` it returns to 0 and a step occurs in the same cycle.
- Step, up: units +1. At 9 the units digit goes to 0 and carries into tens, then tens into hundreds. 999→000 pulses `wrap`.
- Step, down: units −1. At 0 the units digit goes to 9 and borrows from tens, then tens from hundreds. 000→999 pulses `wrap`.
- Digits never hold a non-BCD value.
- Target compare:
  - Applied only to the post-step value. If it equals `target`: state→DONE, `done` pulses, digits hold.
  - Starting from a count equal to `target` therefore runs a full 1000 steps.
  - If `wrap` and `done` happen on the same step, both pulse.
- A non-BCD `target` never matches, so the count runs indefinitely.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Command sampled at edge N → state, digits and pulse outputs update at edge N.
- Start latency: start sampled at edge N → `busy` high after edge N. The first digit change occurs at edge N+`TICK_DIV`.
- Steps in uninterrupted RUN are exactly `TICK_DIV` cycles apart. With `TICK_DIV`=1, the count steps every cycle.
- Pause timing: stop at edge P with prescaler value k, then start at edge S. The next step is at edge S+(`TICK_DIV`−k). Total run cycles between steps are preserved.
- `done`, `wrap` and `load_err` are high for exactly one cycle.
- When a step reaches the target at edge N, the state is DONE after edge N and `busy` is low.
- Asynchronous reset mid-RUN: everything returns to its reset values immediately. After deassertion the block stays in IDLE until `start`.
- A clear and a step scheduled on the same edge resolve to clear; the step is lost.

## Test plan
- Reset with `TICK_DIV`=2, target 005, dir 0, pulse start → digits 001..005 at 2-cycle spacing; `done` pulses at 005; state DONE; `busy` 0; digits hold at 005.
- Load 998, target 002, dir 0, start → steps 999, 000 (`wrap` pulse), 001, 002 (`done` pulse). Repeat with load 001, dir 1, target 998 → `wrap` on 000→999, `done` at 998.
- Start with `TICK_DIV`=4, stop when the prescaler is 2, wait 20 cycles, start again → no digit change while paused; next step lands 2 cycles after the restart.
- Load `load_val`=0x1A3 in IDLE → `load_err` pulses 1 cycle; digits unchanged. Load 0x123 during RUN → ignored, no error.
- Assert clear, load and start together during RUN → digits 000, state IDLE; load not applied.
- Pull `rst` low mid-count at count 047 → digits 000 and `busy` 0 without waiting for a clock edge; nothing counts after release until `start`.

Source files
------------

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: run/pause/terminate controller for a 3-digit BCD counter
// Ports:
//    clk                      rising-edge clock
//    rst                      asynchronous active-low reset
//    start, stop, clear, load commands, priority clear > load > stop > start
//    load_val[11:0]           BCD preset {hundreds, tens, units}
//    dir                      0 counts up, 1 counts down
//    target[11:0]             BCD terminal value, same packing as load_val
//    units, tens, hundreds    registered BCD digits
//    busy                     high while counting (RUN)
//    done, wrap, load_err     one-cycle pulses: target reached, 999/000 crossing, bad preset
module bcd_count_ctrl #(
   parameter int TICK_DIV = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        load,
   input  logic [11:0] load_val,
   input  logic        dir,
   input  logic [11:0] target,
   output logic [3:0]  units,
   output logic [3:0]  tens,
   output logic [3:0]  hundreds,
   output logic        busy,
   output logic        done,
   output logic        wrap,
   output logic        load_err
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   localparam logic [9:0] LAST = 10'(TICK_DIV - 1);
   state_t state, state_n;
   logic [9:0] pre, pre_n;
   logic [11:0] cnt, cnt_n, stepped;
   logic done_n, wrap_n, err_n, run, tick, lv_ok, c_u, c_t, c_w;

   function automatic logic [3:0] nib(input logic [3:0] d, input logic dn);
      return dn ? (d == 4'd0 ? 4'd9 : d - 4'd1) : (d == 4'd9 ? 4'd0 : d + 4'd1);
   endfunction

   function automatic logic lim(input logic [3:0] d, input logic dn);
      return dn ? d == 4'd0 : d == 4'd9;
   endfunction

   assign {hundreds, tens, units} = cnt;
   assign busy = state == RUN;
   assign lv_ok = load_val[3:0] <= 4'd9 && load_val[7:4] <= 4'd9 && load_val[11:8] <= 4'd9;
   // carry/borrow ripples from units upward; a full ripple is the 999/000 crossing
   assign c_u = lim(cnt[3:0], dir);
   assign c_t = c_u && lim(cnt[7:4], dir);
   assign c_w = c_t && lim(cnt[11:8], dir);
   assign stepped = {c_t ? nib(cnt[11:8], dir) : cnt[11:8],
                     c_u ? nib(cnt[7:4], dir) : cnt[7:4],
                     nib(cnt[3:0], dir)};
   // counting continues in RUN unless clear or an acting stop; a load in RUN is ignored
   assign run = state == RUN && !clear && (load || !stop);
   assign tick = run && pre == LAST;

   always_comb begin
      state_n = state;
      pre_n = pre;
      cnt_n = cnt;
      done_n = 1'b0;
      wrap_n = 1'b0;
      err_n = 1'b0;
      if (clear) begin
         cnt_n = '0;
         pre_n = '0;
         state_n = IDLE;
      end else if (load) begin
         if (state != RUN) begin
            if (lv_ok) begin
               cnt_n = load_val;
               pre_n = '0;
               state_n = IDLE;
            end else err_n = 1'b1;
         end
      end else if (stop) begin
         if (state == RUN) state_n = PAUSE;
      end else if (start && state != RUN) begin
         state_n = RUN;
         if (state != PAUSE) pre_n = '0;
      end
      if (run) begin
         pre_n = tick ? 10'd0 : pre + 10'd1;
         if (tick) begin
            cnt_n = stepped;
            wrap_n = c_w;
            // stepped is always BCD, so a non-BCD target can never match
            if (stepped == target) begin
               state_n = DONE;
               done_n = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         pre <= '0;
         cnt <= '0;
         done <= 1'b0;
         wrap <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state <= state_n;
         pre <= pre_n;
         cnt <= cnt_n;
         done <= done_n;
         wrap <= wrap_n;
         load_err <= err_n;
      end
   end
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: scoreboard bench for bcd_count_ctrl at TICK_DIV 1, 2 and 4
module tb_bcd_count_ctrl;
   typedef struct packed {
      logic [11:0] d;
      logic b, dn, w, e;
   } exp_t;

   logic clk = 0, rst = 0, start = 0, stop = 0, clear = 0, load = 0, dir = 0;
   logic [11:0] load_val = 0, target = 0;
   logic [3:0] u[3], t[3], h[3];
   logic busy[3], done[3], wrap[3], lerr[3];
   exp_t q[3][$];
   exp_t e, a;
   int vec = 0, miss = 0;
   int st[3], cnt[3], pre[3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bcd_count_ctrl #(.TICK_DIV(g == 0 ? 1 : g == 1 ? 2 : 4)) dut (
         .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
         .load(load), .load_val(load_val), .dir(dir), .target(target),
         .units(u[g]), .tens(t[g]), .hundreds(h[g]), .busy(busy[g]),
         .done(done[g]), .wrap(wrap[g]), .load_err(lerr[g]));
   end

   function automatic int dv(int i);
      return i == 0 ? 1 : i == 1 ? 2 : 4;
   endfunction

   function automatic bit ok(logic [11:0] v);
      return v[3:0] <= 9 && v[7:4] <= 9 && v[11:8] <= 9;
   endfunction

   function automatic int b2i(logic [11:0] v);
      return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [11:0] i2b(int n);
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   // states: 0 idle, 1 run, 2 pause, 3 done; count is a plain integer 0..999
   task automatic model(int i);
      bit cnt_on = 0, dn = 0, w = 0, er = 0;
      if (clear) begin cnt[i] = 0; pre[i] = 0; st[i] = 0; end
      else if (load) begin
         if (st[i] == 1) cnt_on = 1;
         else if (ok(load_val)) begin cnt[i] = b2i(load_val); pre[i] = 0; st[i] = 0; end
         else er = 1;
      end else if (stop) begin
         if (st[i] == 1) st[i] = 2;
      end else if (start) begin
         if (st[i] == 1) cnt_on = 1;
         else begin
            if (st[i] != 2) pre[i] = 0;
            st[i] = 1;
         end
      end else cnt_on = st[i] == 1;
      if (cnt_on) begin
         if (pre[i] == dv(i) - 1) begin
            pre[i] = 0;
            w = dir ? cnt[i] == 0 : cnt[i] == 999;
            cnt[i] = dir ? (cnt[i] + 999) % 1000 : (cnt[i] + 1) % 1000;
            if (ok(target) && cnt[i] == b2i(target)) begin st[i] = 3; dn = 1; end
         end else pre[i]++;
      end
      q[i].push_back({i2b(cnt[i]), st[i] == 1, dn, w, er});
   endtask

   task automatic mreset();
      for (int i = 0; i < 3; i++) begin st[i] = 0; cnt[i] = 0; pre[i] = 0; end
   endtask

   task automatic cyc();
      for (int i = 0; i < 3; i++) model(i);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic cmd(bit s, bit p, bit c, bit l, logic [11:0] lv);
      start = s; stop = p; clear = c; load = l; load_val = lv;
      cyc();
      start = 0; stop = 0; clear = 0; load = 0;
   endtask

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 3; i++)
         if (q[i].size() != 0) begin
            e = q[i].pop_front();
            a = {h[i], t[i], u[i], busy[i], done[i], wrap[i], lerr[i]};
            vec++;
            if (a !== e) begin
               miss++;
               $display("FAIL dut%0d outputs {digits,busy,done,wrap,err}: got %h/%b%b%b%b want %h/%b%b%b%b",
                        i, a.d, a.b, a.dn, a.w, a.e, e.d, e.b, e.dn, e.w, e.e);
            end
         end
   end

   task automatic rst_check(string nm);
      for (int i = 0; i < 3; i++) begin
         vec++;
         if ({h[i], t[i], u[i]} !== 12'h000 || busy[i] !== 1'b0) begin
            miss++;
            $display("FAIL dut%0d %s: digits %h busy %b, want 000 busy 0", i, nm, {h[i], t[i], u[i]}, busy[i]);
         end
      end
   endtask

   initial begin
      mreset();
      repeat (2) @(posedge clk);
      #2;
      rst_check("reset_hold");
      rst = 1;
      idle(1);
      target = 12'h005;
      cmd(1, 0, 0, 0, 0);
      idle(24);
      cmd(0, 0, 1, 0, 0);
      target = 12'h002;
      cmd(0, 0, 0, 1, 12'h998);
      cmd(1, 0, 0, 0, 0);
      idle(20);
      cmd(0, 0, 1, 0, 0);
      dir = 1;
      target = 12'h998;
      cmd(0, 0, 0, 1, 12'h001);
      cmd(1, 0, 0, 0, 0);
      idle(16);
      cmd(0, 0, 1, 0, 0);
      dir = 0;
      target = 12'hfff;
      cmd(1, 0, 0, 0, 0);
      idle(2);
      cmd(0, 1, 0, 0, 0);
      idle(20);
      cmd(1, 0, 0, 0, 0);
      idle(8);
      cmd(0, 0, 1, 0, 0);
      cmd(0, 0, 0, 1, 12'h1a3);
      idle(2);
      cmd(1, 0, 0, 0, 0);
      idle(1);
      cmd(0, 0, 0, 1, 12'h123);
      idle(3);
      cmd(1, 0, 1, 1, 12'h456);
      idle(2);
      cmd(0, 0, 0, 1, 12'h040);
      cmd(1, 0, 0, 0, 0);
      for (int k = 0; k < 100 && cnt[1] != 47; k++) cyc();
      #3;
      rst = 0;
      #1;
      rst_check("async_reset");
      mreset();
      @(posedge clk);
      #2;
      rst = 1;
      idle(6);
      cmd(1, 0, 0, 0, 0);
      idle(6);
      for (int k = 0; k < 3000; k++) begin
         clear = $urandom_range(0, 99) < 2;
         load = $urandom_range(0, 99) < 4;
         stop = $urandom_range(0, 99) < 5;
         start = $urandom_range(0, 99) < 10;
         load_val = $urandom_range(0, 9) == 0 ? 12'($urandom) : i2b($urandom_range(0, 999));
         if ($urandom_range(0, 49) == 0) dir = ~dir;
         if ($urandom_range(0, 29) == 0)
            target = $urandom_range(0, 19) == 0 ? 12'hfff : i2b($urandom_range(0, 999));
         cyc();
      end
      start = 0; stop = 0; clear = 0; load = 0;
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
